// File: rtl/clock_stop_seq_pkg.sv
// Shared definitions for the clock stop/start sequencer: FSM encoding and
// default delay constants.
package clock_stop_seq_pkg;

  // Sequencer states. STOPPED is the reset state.
  typedef enum logic [1:0] {
    RUN        = 2'd0,
    STOP_WAIT  = 2'd1,
    STOPPED    = 2'd2,
    START_WAIT = 2'd3
  } state_e;

  // Default drain / restart intervals in clk_in cycles, and counter width.
  localparam int unsigned DEF_STOP_DELAY  = 4;
  localparam int unsigned DEF_START_DELAY = 6;
  localparam int unsigned DEF_CNT_W       = 16;

endpackage

// File: rtl/clock_stop_seq_clk_gate_cell.sv
// Glitch-free clock gate: negedge enable latch followed by an AND gate.
// Isolated so it can be replaced by a vendor ICG / BUFGCE primitive.
module clock_stop_seq_clk_gate_cell (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic en_lat_o,
  output logic gclk_o
);

  logic en_lat_q;

  // Enable only changes while clk_i is low, so gclk_o never gets a runt pulse.
  always_ff @(negedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      en_lat_q <= 1'b0;
    end else begin
      en_lat_q <= en_i;
    end
  end

  assign en_lat_o = en_lat_q;
  assign gclk_o   = clk_i & en_lat_q;

endmodule

// File: rtl/clock_stop_seq.sv
// Clock stop/start sequencer: on a level stop request, drains for STOP_DELAY
// cycles then gates the downstream clock off and acknowledges; on release,
// waits START_DELAY cycles then re-enables the clock and drops the ack.
module clock_stop_seq
  import clock_stop_seq_pkg::*;
#(
  parameter int unsigned STOP_DELAY  = DEF_STOP_DELAY,
  parameter int unsigned START_DELAY = DEF_START_DELAY,
  parameter int unsigned CNT_W       = DEF_CNT_W
) (
  input  logic clk_in,
  input  logic rst,
  input  logic stop_req,
  output logic stop_ack,
  output logic busy,
  output logic clk_running,
  output logic clk_out
);

  localparam logic [CNT_W-1:0] STOP_LAST  = CNT_W'(STOP_DELAY - 1);
  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_DELAY - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             en_q, en_d;
  logic             ack_q, ack_d;
  logic             busy_q, busy_d;

  // Saturating increment: the counter never wraps back into a terminal value.
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

  // Next-state, counter and registered-output decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      STOPPED: begin
        if (!stop_req) begin
          state_d = START_WAIT;
          cnt_d   = '0;
        end
      end
      START_WAIT: begin
        // A re-asserted request wins over a simultaneous terminal count.
        if (stop_req) begin
          state_d = STOPPED;
        end else if (cnt_q == START_LAST) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      RUN: begin
        if (stop_req) begin
          state_d = STOP_WAIT;
          cnt_d   = '0;
        end
      end
      STOP_WAIT: begin
        // A released request wins over a simultaneous terminal count.
        if (!stop_req) begin
          state_d = RUN;
        end else if (cnt_q == STOP_LAST) begin
          state_d = STOPPED;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = STOPPED;
      end
    endcase
    en_d   = (state_d == RUN)      || (state_d == STOP_WAIT);
    ack_d  = (state_d == STOPPED)  || (state_d == START_WAIT);
    busy_d = (state_d == STOP_WAIT) || (state_d == START_WAIT);
  end

  // State, counter and output registers; reset parks the clock stopped.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q <= STOPPED;
      cnt_q   <= '0;
      en_q    <= 1'b0;
      ack_q   <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
    end
  end

  clock_stop_seq_clk_gate_cell u_clk_gate_cell (
    .clk_i    (clk_in),
    .rst_i    (rst),
    .en_i     (en_q),
    .en_lat_o (clk_running),
    .gclk_o   (clk_out)
  );

  assign stop_ack = ack_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_clock_stop_seq.sv
// Self-checking bench for clock_stop_seq: a request/countdown model checked on
// every clock half-cycle, plus directed scenarios with literal expectations.
module tb_clock_stop_seq;

  localparam int STOP_D  = 4;
  localparam int START_D = 6;

  logic clk_in   = 1'b0;
  logic rst      = 1'b0;
  logic stop_req = 1'b0;
  logic stop_ack, busy, clk_running, clk_out;

  int checks = 0;
  int errors = 0;

  clock_stop_seq #(
    .STOP_DELAY  (STOP_D),
    .START_DELAY (START_D),
    .CNT_W       (16)
  ) dut (
    .clk_in      (clk_in),
    .rst         (rst),
    .stop_req    (stop_req),
    .stop_ack    (stop_ack),
    .busy        (busy),
    .clk_running (clk_running),
    .clk_out     (clk_out)
  );

  always #10 clk_in = ~clk_in;

  task automatic check(input string name, input int actual, input int required);
    checks++;
    if (actual != required) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, actual, required, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The settled clock condition is "ack": 1 = stopped. Whenever the sampled
  // request disagrees with it, a countdown of the matching delay runs; the
  // request agreeing again cancels it, reaching zero adopts the request.
  logic m_ack  = 1'b1;
  logic m_busy = 1'b0;
  logic m_lat  = 1'b0;
  logic m_pend = 1'b0;
  int   m_rem  = 0;

  always begin
    logic r;
    @(posedge clk_in or negedge clk_in or posedge rst);
    if (rst) begin
      m_ack = 1'b1; m_busy = 1'b0; m_lat = 1'b0; m_pend = 1'b0; m_rem = 0;
    end else if (clk_in) begin
      r = stop_req;
      if (!m_pend) begin
        if (r != m_ack) begin
          m_pend = 1'b1;
          m_rem  = r ? STOP_D : START_D;
        end
      end else if (r == m_ack) begin
        m_pend = 1'b0;
      end else begin
        m_rem--;
        if (m_rem == 0) begin
          m_ack  = r;
          m_pend = 1'b0;
        end
      end
      m_busy = m_pend;
    end else begin
      // The clock enable is simply "not stopped", picked up on the low phase.
      m_lat = !m_ack;
    end
    #1;
    check("model_ack", int'(stop_ack), int'(m_ack));
    check("model_busy", int'(busy), int'(m_busy));
    check("model_running", int'(clk_running), int'(m_lat));
    check("model_clk_out", int'(clk_out), int'(clk_in & m_lat));
  end

  // ---------------- clk_out pulse monitor ----------------
  int pulse_cnt = 0;
  int last_rise = 0;

  always @(posedge clk_out) begin
    pulse_cnt++;
    last_rise = int'($time);
  end

  // Every gated pulse must be a full half period wide.
  always @(negedge clk_out) begin
    check("pulse_width", int'($time) - last_rise, 10);
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive_req(input logic v);
    @(negedge clk_in);
    #2;
    stop_req = v;
  endtask

  task automatic edge_sample();
    @(posedge clk_in);
    #1;
  endtask

  // Counts edges (from the next one) until stop_ack equals target; bounded.
  task automatic edges_until_ack(input logic target, output int n);
    n = 0;
    do begin
      edge_sample();
      n++;
    end while (stop_ack != target && n < 50);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int n;
    int busy_cycles;

    #1 rst = 1'b1;
    #5;
    check("reset_ack", int'(stop_ack), 1);
    check("reset_busy", int'(busy), 0);
    check("reset_running", int'(clk_running), 0);
    check("reset_clk_out", int'(clk_out), 0);

    // Start from reset: first sampling edge at 50 ns, ack falls 6 edges later
    // (170 ns, the 7th edge), first gated rise at 190 ns.
    #34 rst = 1'b0;
    n = 0;
    busy_cycles = 0;
    do begin
      edge_sample();
      n++;
      busy_cycles += int'(busy);
    end while (stop_ack && n < 50);
    check("start_edges", n, 7);
    check("start_ack_time", int'($time), 171);
    check("start_busy_cycles", busy_cycles, 6);
    check("start_no_pulse_yet", pulse_cnt, 0);
    edge_sample();
    check("start_first_rise_time", last_rise, 190);
    check("start_first_pulse", pulse_cnt, 1);
    repeat (3) edge_sample();

    // Stop from RUN: exactly 4 pulses after E0, ack at E0+4.
    drive_req(1'b1);
    edge_sample();
    pulse_cnt = 0;
    edges_until_ack(1'b1, n);
    check("stop_ack_edges", n, STOP_D);
    repeat (6) edge_sample();
    check("stop_pulses", pulse_cnt, 4);
    check("stop_clk_out_low", int'(clk_out), 0);

    // Start from STOPPED: silent for 6 cycles, ack=0 at E0+6, then running.
    drive_req(1'b0);
    edge_sample();
    pulse_cnt = 0;
    edges_until_ack(1'b0, n);
    check("restart_ack_edges", n, START_D);
    check("restart_silent", pulse_cnt, 0);
    repeat (3) edge_sample();
    check("restart_pulses", pulse_cnt, 3);

    // Abort a stop after 2 cycles: 11 uninterrupted pulses over E0+1..E0+11.
    drive_req(1'b1);
    edge_sample();
    pulse_cnt = 0;
    edge_sample();
    drive_req(1'b0);
    repeat (10) edge_sample();
    check("abort_stop_pulses", pulse_cnt, 11);
    check("abort_stop_ack", int'(stop_ack), 0);
    check("abort_stop_busy", int'(busy), 0);

    // Get to STOPPED, then abort a start after 3 cycles: clock never runs.
    drive_req(1'b1);
    repeat (8) edge_sample();
    check("pre_abort_start_ack", int'(stop_ack), 1);
    drive_req(1'b0);
    edge_sample();
    pulse_cnt = 0;
    repeat (2) edge_sample();
    drive_req(1'b1);
    repeat (10) edge_sample();
    check("abort_start_pulses", pulse_cnt, 0);
    check("abort_start_ack", int'(stop_ack), 1);
    check("abort_start_busy", int'(busy), 0);

    // Run again, enter STOP_WAIT, then reset between edges.
    drive_req(1'b0);
    repeat (10) edge_sample();
    check("pre_reset_ack", int'(stop_ack), 0);
    drive_req(1'b1);
    edge_sample();
    repeat (2) edge_sample();
    check("mid_stop_wait_busy", int'(busy), 1);
    @(negedge clk_in);
    #3;
    stop_req = 1'b0;
    rst = 1'b1;
    #1;
    check("async_rst_ack", int'(stop_ack), 1);
    check("async_rst_clk_out", int'(clk_out), 0);
    check("async_rst_running", int'(clk_running), 0);
    check("async_rst_busy", int'(busy), 0);
    @(posedge clk_in);
    @(negedge clk_in);
    #3;
    rst = 1'b0;
    pulse_cnt = 0;
    edges_until_ack(1'b0, n);
    check("post_rst_start_edges", n, 7);
    check("post_rst_silent", pulse_cnt, 0);
    repeat (4) edge_sample();
    check("post_rst_pulses", pulse_cnt, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
